svx32_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single sparrowx32 data-memory port between the core's memory unit and the program-loader/debug port. It sits between `svx32_core` (mem-unit signals) and the data memory. The memory protocol is used unchanged on every side: req held until ack, then exactly one valid pulse per accepted transaction. Round-robin fairness, one outstanding transaction, and a timeout watchdog that guarantees every granted requester eventually gets a valid.

---
 rtl/svx32_pkg.sv | 26 ++
 rtl/svx32_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_svx32_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/svx32_pkg.sv
// ----------------------------------------------------------------------------
// svx32_pkg
// Shared types for the sparrowx32 memory arbiter:
//   arb_state_t : arbiter FSM states (IDLE / REQ / RSP)
//   mem_req_t   : request payload latched at grant (wen, addr, wdata, byte_sel)
//   OWN_CORE / OWN_LDR : owner encoding used by the grant and pointer registers
// ----------------------------------------------------------------------------
package svx32_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RSP  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  byte_sel;
   } mem_req_t;

   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_LDR  = 1'b1;

endpackage

// File: rtl/svx32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// svx32_mem_arbiter
// Shares the single data-memory port between the core mem unit (c) and the
// program-loader/debug port (l). Round-robin between simultaneous requests,
// one outstanding transaction, and a watchdog that aborts a transaction that
// sees no ack/valid within TIMEOUT_CYCLES cycles of REQ+RSP.
//
// Ports:
//   pil_clk, pil_rst            : clock, async active-low reset
//   pil/piv_{c,l}_*             : requester request side (req, wen, addr, wdata, byte_sel)
//   pol/pov_{c,l}_*             : requester response side (ack, valid, rdata), combinational
//   pol/pov_mem_*               : memory request side, registered
//   pil/piv_mem_*               : memory response side (ack, valid, rdata)
//   pol_timeout                 : one-cycle pulse on watchdog abort
// ----------------------------------------------------------------------------
module svx32_mem_arbiter
   import svx32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        pil_clk,
   input  logic        pil_rst,
   input  logic        pil_c_req,
   input  logic        pil_c_wen,
   input  logic [31:0] piv_c_addr,
   input  logic [31:0] piv_c_wdata,
   input  logic [3:0]  piv_c_byte_sel,
   input  logic        pil_l_req,
   input  logic        pil_l_wen,
   input  logic [31:0] piv_l_addr,
   input  logic [31:0] piv_l_wdata,
   input  logic [3:0]  piv_l_byte_sel,
   output logic        pol_c_ack,
   output logic        pol_c_valid,
   output logic [31:0] pov_c_rdata,
   output logic        pol_l_ack,
   output logic        pol_l_valid,
   output logic [31:0] pov_l_rdata,
   output logic        pol_mem_req,
   output logic        pol_mem_wen,
   output logic [31:0] pov_mem_addr,
   output logic [31:0] pov_mem_wdata,
   output logic [3:0]  pov_mem_byte_sel,
   input  logic        pil_mem_ack,
   input  logic        pil_mem_valid,
   input  logic [31:0] piv_mem_rdata,
   output logic        pol_timeout
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       r_state;
   logic             r_owner;
   logic             r_ptr;
   logic [CNT_W-1:0] r_cnt;
   mem_req_t         r_req;
   logic             r_mem_req;

   arb_state_t       w_state_nxt;
   logic             w_grant;
   logic             w_sel_owner;
   mem_req_t         w_sel_req;
   logic             w_ack;
   logic             w_valid;
   logic [31:0]      w_rdata;
   logic             w_abort;
   logic             w_done;
   logic             w_cnt_last;

   assign w_cnt_last = (r_cnt == CNT_LAST);

   // Round-robin pick: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      w_sel_owner = r_ptr;
      if (pil_c_req && !pil_l_req) begin
         w_sel_owner = OWN_CORE;
      end else if (pil_l_req && !pil_c_req) begin
         w_sel_owner = OWN_LDR;
      end

      w_sel_req.wen      = pil_c_wen;
      w_sel_req.addr     = piv_c_addr;
      w_sel_req.wdata    = piv_c_wdata;
      w_sel_req.byte_sel = piv_c_byte_sel;
      if (w_sel_owner == OWN_LDR) begin
         w_sel_req.wen      = pil_l_wen;
         w_sel_req.addr     = piv_l_addr;
         w_sel_req.wdata    = piv_l_wdata;
         w_sel_req.byte_sel = piv_l_byte_sel;
      end
   end

   // State register.
   always_ff @(posedge pil_clk or negedge pil_rst) begin
      if (!pil_rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus the requester-facing response strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_ack       = 1'b0;
      w_valid     = 1'b0;
      w_rdata     = 32'd0;
      w_abort     = 1'b0;
      w_done      = 1'b0;

      case (r_state)
         ARB_IDLE: begin
            if (pil_c_req || pil_l_req) begin
               w_grant     = 1'b1;
               w_state_nxt = ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (pil_mem_ack) begin
               w_ack = 1'b1;
               if (pil_mem_valid) begin
                  w_valid     = 1'b1;
                  w_rdata     = piv_mem_rdata;
                  w_done      = 1'b1;
                  w_state_nxt = ARB_IDLE;
               end else begin
                  w_state_nxt = ARB_RSP;
               end
            end else if (w_cnt_last) begin
               // Abort while still unacknowledged: owner gets both ack and valid.
               w_abort     = 1'b1;
               w_ack       = 1'b1;
               w_valid     = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = ARB_IDLE;
            end
         end
         ARB_RSP: begin
            if (pil_mem_valid) begin
               w_valid     = 1'b1;
               w_rdata     = piv_mem_rdata;
               w_done      = 1'b1;
               w_state_nxt = ARB_IDLE;
            end else if (w_cnt_last) begin
               w_abort     = 1'b1;
               w_valid     = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = ARB_IDLE;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   // Grant latch, watchdog counter, priority pointer and memory request.
   always_ff @(posedge pil_clk or negedge pil_rst) begin
      if (!pil_rst) begin
         r_owner   <= OWN_CORE;
         r_ptr     <= OWN_CORE;
         r_cnt     <= '0;
         r_req     <= '0;
         r_mem_req <= 1'b0;
      end else begin
         if (w_grant) begin
            r_owner <= w_sel_owner;
            r_req   <= w_sel_req;
            r_cnt   <= '0;
         end else if ((r_state != ARB_IDLE) && !w_cnt_last) begin
            // Saturates at the abort threshold; never wraps.
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_done) begin
            r_ptr <= ~r_owner;
         end
         r_mem_req <= (w_state_nxt == ARB_REQ);
      end
   end

   assign pol_mem_req      = r_mem_req;
   assign pol_mem_wen      = r_req.wen;
   assign pov_mem_addr     = r_req.addr;
   assign pov_mem_wdata    = r_req.wdata;
   assign pov_mem_byte_sel = r_req.byte_sel;

   // Steer the response strobes to the owner only; rdata is zero unless valid.
   assign pol_c_ack   = w_ack   && (r_owner == OWN_CORE);
   assign pol_c_valid = w_valid && (r_owner == OWN_CORE);
   assign pov_c_rdata = pol_c_valid ? w_rdata : 32'd0;
   assign pol_l_ack   = w_ack   && (r_owner == OWN_LDR);
   assign pol_l_valid = w_valid && (r_owner == OWN_LDR);
   assign pov_l_rdata = pol_l_valid ? w_rdata : 32'd0;
   assign pol_timeout = w_abort;

endmodule

// File: tb/tb_svx32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_svx32_mem_arbiter
// Self-checking bench for svx32_mem_arbiter (TIMEOUT_CYCLES = 4): a cycle
// table of directed vectors, hand-written multi-cycle sequences (round-robin,
// async reset mid-transaction) and a randomized run against a
// transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_svx32_mem_arbiter;
   import svx32_pkg::*;

   localparam int T = 4;

   logic        clk;
   logic        rst_n;
   logic        c_req, c_wen, l_req, l_wen;
   logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
   logic [3:0]  c_bs, l_bs;
   logic        c_ack, c_valid, l_ack, l_valid;
   logic [31:0] c_rdata, l_rdata;
   logic        mem_req, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_bs;
   logic        mem_ack, mem_valid;
   logic [31:0] mem_rdata;
   logic        timeout;

   int n_assert = 0;
   int n_fail   = 0;

   svx32_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .pil_clk(clk), .pil_rst(rst_n),
      .pil_c_req(c_req), .pil_c_wen(c_wen), .piv_c_addr(c_addr),
      .piv_c_wdata(c_wdata), .piv_c_byte_sel(c_bs),
      .pil_l_req(l_req), .pil_l_wen(l_wen), .piv_l_addr(l_addr),
      .piv_l_wdata(l_wdata), .piv_l_byte_sel(l_bs),
      .pol_c_ack(c_ack), .pol_c_valid(c_valid), .pov_c_rdata(c_rdata),
      .pol_l_ack(l_ack), .pol_l_valid(l_valid), .pov_l_rdata(l_rdata),
      .pol_mem_req(mem_req), .pol_mem_wen(mem_wen), .pov_mem_addr(mem_addr),
      .pov_mem_wdata(mem_wdata), .pov_mem_byte_sel(mem_bs),
      .pil_mem_ack(mem_ack), .pil_mem_valid(mem_valid), .piv_mem_rdata(mem_rdata),
      .pol_timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        c, l, a, v;
      logic [31:0] rd;
      logic        mreq, wen;
      logic [31:0] addr;
      logic [4:0]  flg;   // {c_ack, c_valid, l_ack, l_valid, timeout}
      logic [31:0] crd, lrd;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input logic c, l, a, v, input logic [31:0] rd,
                               input logic mreq, wen, input logic [31:0] addr,
                               input logic [4:0] flg, input logic [31:0] crd, lrd);
      vec_t x;
      x.c = c; x.l = l; x.a = a; x.v = v; x.rd = rd;
      x.mreq = mreq; x.wen = wen; x.addr = addr; x.flg = flg; x.crd = crd; x.lrd = lrd;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge, settle, then return.
   task automatic step(input logic c, l, a, v, input logic [31:0] rd);
      @(negedge clk);
      c_req = c; l_req = l; mem_ack = a; mem_valid = v; mem_rdata = rd;
      #1;
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, 64'(|{mem_req, mem_wen, mem_addr, mem_wdata, mem_bs, c_ack, c_valid,
                      l_ack, l_valid, timeout, c_rdata, l_rdata}), 64'd0);
   endtask

   task automatic do_reset();
      c_req = 0; l_req = 0; mem_ack = 0; mem_valid = 0; mem_rdata = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 chk_all_zero("reset_outputs");
      rst_n = 1'b1;
   endtask

   task automatic set_fixed_fields();
      c_wen = 1'b0; c_addr = 32'h100; c_wdata = 32'hAAAA0001; c_bs = 4'hF;
      l_wen = 1'b1; l_addr = 32'h200; l_wdata = 32'h55550002; l_bs = 4'h3;
   endtask

   // Reference-model state (transaction level).
   logic     m_busy, m_acked, m_owner, m_ptr;
   int       m_since;
   mem_req_t m_fields;

   initial begin
      logic        found;
      logic [31:0] exp_addr;
      logic        c_pend, l_pend;
      logic        e_ack, e_val, e_to, e_mreq;
      logic [31:0] e_rd;

      // Directed cycle table (starts in IDLE right after reset, pointer = core).
      tbl[0]  = mk(1,0,0,0,32'h0,        0,0,32'h0,   5'b00000, 32'h0, 32'h0);
      tbl[1]  = mk(1,0,0,0,32'h0,        1,0,32'h100, 5'b00000, 32'h0, 32'h0);
      tbl[2]  = mk(1,0,1,0,32'h0,        1,0,32'h100, 5'b10000, 32'h0, 32'h0);
      tbl[3]  = mk(0,0,0,1,32'hDEADBEEF, 0,0,32'h0,   5'b01000, 32'hDEADBEEF, 32'h0);
      tbl[4]  = mk(0,0,0,1,32'h11111111, 0,0,32'h0,   5'b00000, 32'h0, 32'h0);
      tbl[5]  = mk(0,1,0,0,32'h0,        0,0,32'h0,   5'b00000, 32'h0, 32'h0);
      tbl[6]  = mk(0,1,1,1,32'h12345678, 1,1,32'h200, 5'b00110, 32'h0, 32'h12345678);
      tbl[7]  = mk(1,0,0,0,32'h0,        0,0,32'h0,   5'b00000, 32'h0, 32'h0);
      tbl[8]  = mk(0,0,0,0,32'h0,        1,0,32'h100, 5'b00000, 32'h0, 32'h0);
      tbl[9]  = mk(0,0,1,0,32'h0,        1,0,32'h100, 5'b10000, 32'h0, 32'h0);
      tbl[10] = mk(0,0,0,1,32'hCAFEF00D, 0,0,32'h0,   5'b01000, 32'hCAFEF00D, 32'h0);
      tbl[11] = mk(0,1,0,0,32'h0,        0,0,32'h0,   5'b00000, 32'h0, 32'h0);
      tbl[12] = mk(0,1,0,0,32'h0,        1,1,32'h200, 5'b00000, 32'h0, 32'h0);
      tbl[13] = mk(0,1,0,0,32'hFFFFFFFF, 1,1,32'h200, 5'b00000, 32'h0, 32'h0);
      tbl[14] = mk(0,1,0,0,32'h0,        1,1,32'h200, 5'b00000, 32'h0, 32'h0);
      tbl[15] = mk(0,1,0,0,32'hFFFFFFFF, 1,1,32'h200, 5'b00111, 32'h0, 32'h0);
      tbl[16] = mk(1,0,1,0,32'h0,        0,0,32'h0,   5'b00000, 32'h0, 32'h0);
      tbl[17] = mk(1,0,0,0,32'h0,        1,0,32'h100, 5'b00000, 32'h0, 32'h0);
      tbl[18] = mk(1,0,1,1,32'h0BADF00D, 1,0,32'h100, 5'b11000, 32'h0BADF00D, 32'h0);
      tbl[19] = mk(0,0,0,0,32'h0,        0,0,32'h0,   5'b00000, 32'h0, 32'h0);

      set_fixed_fields();
      do_reset();

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].c, tbl[i].l, tbl[i].a, tbl[i].v, tbl[i].rd);
         chk($sformatf("tbl%0d_flags", i), 64'({c_ack, c_valid, l_ack, l_valid, timeout}), 64'(tbl[i].flg));
         chk($sformatf("tbl%0d_c_rdata", i), 64'(c_rdata), 64'(tbl[i].crd));
         chk($sformatf("tbl%0d_l_rdata", i), 64'(l_rdata), 64'(tbl[i].lrd));
         chk($sformatf("tbl%0d_mem_req", i), 64'(mem_req), 64'(tbl[i].mreq));
         if (tbl[i].mreq) begin
            chk($sformatf("tbl%0d_mem_addr", i), 64'(mem_addr), 64'(tbl[i].addr));
            chk($sformatf("tbl%0d_mem_wen", i), 64'(mem_wen), 64'(tbl[i].wen));
         end
      end

      // Both requesters held continuously: grants must alternate core/loader.
      do_reset();
      step(1, 1, 0, 0, 32'h0);
      for (int t = 0; t < 6; t++) begin
         exp_addr = (t % 2 == 1) ? 32'h200 : 32'h100;
         found = 1'b0;
         for (int k = 0; k < 10 && !found; k++) begin
            step(1, 1, 0, 0, 32'h0);
            found = mem_req;
         end
         chk($sformatf("rr%0d_grant_seen", t), 64'(found), 64'd1);
         chk($sformatf("rr%0d_mem_addr", t), 64'(mem_addr), 64'(exp_addr));
         mem_ack = 1'b1; mem_valid = 1'b1; mem_rdata = 32'(t + 1);
         #1;
         chk($sformatf("rr%0d_acks", t), 64'({c_ack, l_ack}), (t % 2 == 1) ? 64'b01 : 64'b10);
      end

      // Async reset in RSP; pointer must return to core afterwards.
      do_reset();
      step(1, 0, 0, 0, 32'h0);
      step(1, 0, 1, 0, 32'h0);
      step(0, 0, 0, 1, 32'h5);          // core completes: pointer -> loader
      step(1, 0, 0, 0, 32'h0);
      step(1, 0, 1, 0, 32'h0);          // acked, now in RSP
      step(0, 0, 0, 0, 32'h0);
      chk("rst_pre_in_rsp", 64'(mem_req), 64'd0);
      #1 rst_n = 1'b0;
      mem_valid = 1'b1; mem_rdata = 32'h77;
      #1 chk_all_zero("rst_async_outputs");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_release_no_valid", 64'({c_valid, l_valid, c_rdata}), 64'd0);
      step(1, 1, 0, 1, 32'h77);
      chk("rst_late_valid_ignored", 64'({c_valid, l_valid}), 64'd0);
      step(1, 1, 0, 0, 32'h0);
      chk("rst_ptr_core_req", 64'(mem_req), 64'd1);
      chk("rst_ptr_core_addr", 64'(mem_addr), 64'h100);

      // Randomized run against the transaction-level model.
      do_reset();
      m_busy = 0; m_acked = 0; m_owner = 0; m_ptr = 0; m_since = 0; m_fields = '0;
      c_pend = 0; l_pend = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (!c_pend && $urandom_range(0, 3) == 0) begin
            c_pend = 1; c_addr = $urandom; c_wdata = $urandom;
            c_wen = 1'($urandom_range(0, 1)); c_bs = 4'($urandom);
         end else if (c_pend && $urandom_range(0, 31) == 0) begin
            c_pend = 0;
         end
         if (!l_pend && $urandom_range(0, 3) == 0) begin
            l_pend = 1; l_addr = $urandom; l_wdata = $urandom;
            l_wen = 1'($urandom_range(0, 1)); l_bs = 4'($urandom);
         end else if (l_pend && $urandom_range(0, 31) == 0) begin
            l_pend = 0;
         end
         c_req = c_pend; l_req = l_pend;
         mem_ack   = ($urandom_range(0, 2) == 0);
         mem_valid = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         #1;

         e_ack = 0; e_val = 0; e_to = 0; e_rd = 32'h0;
         e_mreq = m_busy && !m_acked;
         if (m_busy) begin
            if (!m_acked && mem_ack) begin
               e_ack = 1;
               if (mem_valid) begin e_val = 1; e_rd = mem_rdata; end
            end else if (m_acked && mem_valid) begin
               e_val = 1; e_rd = mem_rdata;
            end else if (m_since >= T) begin
               e_to = 1; e_val = 1; e_ack = !m_acked;
            end
         end

         chk("rnd_flags", 64'({c_ack, c_valid, l_ack, l_valid, timeout}),
             64'({e_ack && !m_owner, e_val && !m_owner, e_ack && m_owner, e_val && m_owner, e_to}));
         chk("rnd_c_rdata", 64'(c_rdata), (e_val && !m_owner) ? 64'(e_rd) : 64'd0);
         chk("rnd_l_rdata", 64'(l_rdata), (e_val && m_owner) ? 64'(e_rd) : 64'd0);
         chk("rnd_mem_req", 64'(mem_req), 64'(e_mreq));
         if (e_mreq) begin
            chk("rnd_mem_addr", 64'(mem_addr), 64'(m_fields.addr));
            chk("rnd_mem_wdata", 64'(mem_wdata), 64'(m_fields.wdata));
            chk("rnd_mem_wen_bs", 64'({mem_wen, mem_bs}), 64'({m_fields.wen, m_fields.byte_sel}));
         end

         if (m_busy) begin
            if (e_ack) begin
               if (m_owner) l_pend = 0; else c_pend = 0;
            end
            if (e_val) begin
               m_busy = 0;
               m_ptr  = !m_owner;
            end else begin
               if (e_ack) m_acked = 1;
               m_since++;
            end
         end else if (c_req || l_req) begin
            m_owner = (c_req && l_req) ? m_ptr : l_req;
            m_fields = m_owner ? mem_req_t'({l_wen, l_addr, l_wdata, l_bs})
                               : mem_req_t'({c_wen, c_addr, c_wdata, c_bs});
            m_busy = 1; m_acked = 0; m_since = 1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
